// File: rtl/branch_pred_queue_pkg.sv
// Shared types and default sizes for the branch prediction metadata queue.
// The entry layout is fixed by these defaults; PC_W/GHR_W overrides on the top must match them.
package branch_pred_queue_pkg;

  localparam int BPQ_DEPTH = 8;
  localparam int BPQ_PC_W  = 32;
  localparam int BPQ_GHR_W = 8;

  typedef struct packed {
    logic [BPQ_PC_W-1:0]  pc;
    logic [BPQ_GHR_W-1:0] ghr;
    logic                 pred_2lvl;
    logic                 pred_gshare;
    logic                 sel;
  } bpq_entry_t;

  // Prediction the chooser actually acted on for this entry.
  function automatic logic chosen_pred(bpq_entry_t e);
    return e.sel ? e.pred_gshare : e.pred_2lvl;
  endfunction

endpackage

// File: rtl/branch_pred_queue_update_reg.sv
// Registered training outputs: one strobe per committed branch, one cycle after the pop.
module bpq_update_reg
  import branch_pred_queue_pkg::*;
#(
  parameter int PC_W  = BPQ_PC_W,
  parameter int GHR_W = BPQ_GHR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop,
  input  bpq_entry_t       head_entry,
  input  logic             commit_taken,
  output logic             branch_we,
  output logic             misprediction,
  output logic             predictor_used,
  output logic [PC_W-1:0]  upd_pc,
  output logic [GHR_W-1:0] upd_ghr,
  output logic             upd_taken,
  output logic             upd_mispred_2lvl,
  output logic             upd_mispred_gshare
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_we          <= 1'b0;
      misprediction      <= 1'b0;
      predictor_used     <= 1'b0;
      upd_pc             <= '0;
      upd_ghr            <= '0;
      upd_taken          <= 1'b0;
      upd_mispred_2lvl   <= 1'b0;
      upd_mispred_gshare <= 1'b0;
    end else begin
      branch_we <= pop;
      // Payload holds between strobes; consumers only look while branch_we is high.
      if (pop) begin
        misprediction      <= chosen_pred(head_entry) ^ commit_taken;
        predictor_used     <= head_entry.sel;
        upd_pc             <= head_entry.pc;
        upd_ghr            <= head_entry.ghr;
        upd_taken          <= commit_taken;
        upd_mispred_2lvl   <= head_entry.pred_2lvl ^ commit_taken;
        upd_mispred_gshare <= head_entry.pred_gshare ^ commit_taken;
      end
    end
  end

endmodule

// File: rtl/branch_pred_queue.sv
// In-order queue of branch prediction metadata from fetch to commit; drives
// the predictor/chooser training strobe through bpq_update_reg.
module branch_pred_queue
  import branch_pred_queue_pkg::*;
#(
  parameter int DEPTH = BPQ_DEPTH,
  parameter int PC_W  = BPQ_PC_W,
  parameter int GHR_W = BPQ_GHR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [PC_W-1:0]        push_pc,
  input  logic [GHR_W-1:0]       push_ghr,
  input  logic                   push_pred_2lvl,
  input  logic                   push_pred_gshare,
  input  logic                   push_sel,
  input  logic                   commit_valid,
  input  logic                   commit_taken,
  output logic                   commit_ready,
  input  logic                   flush,
  output logic                   branch_we,
  output logic                   misprediction,
  output logic                   predictor_used,
  output logic [PC_W-1:0]        upd_pc,
  output logic [GHR_W-1:0]       upd_ghr,
  output logic                   upd_taken,
  output logic                   upd_mispred_2lvl,
  output logic                   upd_mispred_gshare,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;
  bpq_entry_t       push_entry;
  bpq_entry_t       mem [DEPTH];

  // Readiness looks only at registered occupancy, so a full queue refuses a
  // push even in a cycle that also pops.
  assign push_ready   = (count != CNT_W'(DEPTH));
  assign commit_ready = (count != '0);
  assign do_push      = push_valid && push_ready && !flush;
  assign do_pop       = commit_valid && commit_ready;

  assign push_entry = '{pc:          push_pc,
                        ghr:         push_ghr,
                        pred_2lvl:   push_pred_2lvl,
                        pred_gshare: push_pred_gshare,
                        sel:         push_sel};

  // NOTE: the payload array has no reset; occupancy and pointers alone decide
  // which slots are valid, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A pop coincident with flush still trains: that branch retired before the redirect.
  bpq_update_reg #(
    .PC_W  (PC_W),
    .GHR_W (GHR_W)
  ) u_update_reg (
    .clk                (clk),
    .rst                (rst),
    .pop                (do_pop),
    .head_entry         (mem[head]),
    .commit_taken       (commit_taken),
    .branch_we          (branch_we),
    .misprediction      (misprediction),
    .predictor_used     (predictor_used),
    .upd_pc             (upd_pc),
    .upd_ghr            (upd_ghr),
    .upd_taken          (upd_taken),
    .upd_mispred_2lvl   (upd_mispred_2lvl),
    .upd_mispred_gshare (upd_mispred_gshare)
  );

endmodule

// File: tb/tb_branch_pred_queue.sv
// Scoreboard bench for branch_pred_queue: a reference queue predicts every
// update strobe, which a negedge monitor compares against the DUT.
module tb_branch_pred_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, push_ready;
  logic [31:0] push_pc;
  logic [7:0]  push_ghr;
  logic        push_pred_2lvl, push_pred_gshare, push_sel;
  logic        commit_valid, commit_taken, commit_ready;
  logic        flush;
  logic        branch_we, misprediction, predictor_used;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic        upd_taken, upd_mispred_2lvl, upd_mispred_gshare;
  logic [3:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  ghr;
    logic        p2, pg, sel;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  ghr;
    logic        taken, mis, used, m2, mg;
    int          due;
  } exp_t;

  ent_t ref_q[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_pred_queue dut (
    .clk                (clk),
    .rst                (rst),
    .push_valid         (push_valid),
    .push_ready         (push_ready),
    .push_pc            (push_pc),
    .push_ghr           (push_ghr),
    .push_pred_2lvl     (push_pred_2lvl),
    .push_pred_gshare   (push_pred_gshare),
    .push_sel           (push_sel),
    .commit_valid       (commit_valid),
    .commit_taken       (commit_taken),
    .commit_ready       (commit_ready),
    .flush              (flush),
    .branch_we          (branch_we),
    .misprediction      (misprediction),
    .predictor_used     (predictor_used),
    .upd_pc             (upd_pc),
    .upd_ghr            (upd_ghr),
    .upd_taken          (upd_taken),
    .upd_mispred_2lvl   (upd_mispred_2lvl),
    .upd_mispred_gshare (upd_mispred_gshare),
    .count              (count)
  );

  // Monitor: every cycle either exactly the due strobe appears, or none does.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL missing_strobe pc=%h due=%0d now=%0d", e.pc, e.due, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        total++;
        if (branch_we !== 1'b1) begin
          bad++;
          $display("FAIL strobe_present cyc=%0d got=%b want=1 (pc=%h)", cyc, branch_we, e.pc);
        end
        total++;
        if ({upd_pc, upd_ghr, upd_taken, misprediction, predictor_used, upd_mispred_2lvl, upd_mispred_gshare}
            !== {e.pc, e.ghr, e.taken, e.mis, e.used, e.m2, e.mg}) begin
          bad++;
          $display("FAIL strobe_payload cyc=%0d got pc=%h ghr=%h t=%b mis=%b used=%b m2=%b mg=%b want pc=%h ghr=%h t=%b mis=%b used=%b m2=%b mg=%b",
                   cyc, upd_pc, upd_ghr, upd_taken, misprediction, predictor_used, upd_mispred_2lvl,
                   upd_mispred_gshare, e.pc, e.ghr, e.taken, e.mis, e.used, e.m2, e.mg);
        end
      end else begin
        total++;
        if (branch_we !== 1'b0) begin
          bad++;
          $display("FAIL spurious_strobe cyc=%0d got branch_we=%b want=0 upd_pc=%h", cyc, branch_we, upd_pc);
        end
      end
    end
  end

  // One clock of stimulus; the reference model follows the same edge.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic [7:0] ghr,
                       input logic p2, input logic pg, input logic sel,
                       input logic cv, input logic ct, input logic fl);
    ent_t h;
    exp_t x;
    bit   can_push;
    push_valid = pv; push_pc = pc; push_ghr = ghr;
    push_pred_2lvl = p2; push_pred_gshare = pg; push_sel = sel;
    commit_valid = cv; commit_taken = ct; flush = fl;
    can_push = pv && (ref_q.size() < 8) && !fl;
    if (cv && ref_q.size() > 0) begin
      h = ref_q.pop_front();
      x.pc = h.pc; x.ghr = h.ghr; x.taken = ct;
      x.mis = (h.sel ? h.pg : h.p2) ^ ct;
      x.used = h.sel; x.m2 = h.p2 ^ ct; x.mg = h.pg ^ ct;
      x.due = cyc + 1;
      exp_q.push_back(x);
    end
    if (can_push) begin
      h.pc = pc; h.ghr = ghr; h.p2 = p2; h.pg = pg; h.sel = sel;
      ref_q.push_back(h);
    end
    if (fl) ref_q.delete();
    @(posedge clk);
    #1;
    push_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [7:0] ghr,
                          input logic p2, input logic pg, input logic sel);
    cycle(1'b1, pc, ghr, p2, pg, sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit_one(input logic ct);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, ct, 1'b0);
  endtask

  task automatic check_count(input string name);
    total++;
    if (count !== 4'(ref_q.size())) begin
      bad++;
      $display("FAIL %s count got=%0d want=%0d", name, count, ref_q.size());
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) push_one(32'hA0 + 32'(i), 8'(i + 1), 1'b1, 1'b1, 1'b1);
    commit_one(1'b1);
    commit_valid = 1'b1;
    #2 rst = 1'b1;
    exp_q.delete();
    ref_q.delete();
    #1;
    total++;
    if ({branch_we, misprediction, predictor_used, upd_taken, upd_mispred_2lvl, upd_mispred_gshare} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {branch_we, misprediction, predictor_used,
               upd_taken, upd_mispred_2lvl, upd_mispred_gshare});
    end
    total++;
    if ({upd_pc, upd_ghr} !== 40'h0) begin
      bad++;
      $display("FAIL reset_upd got pc=%h ghr=%h want 0", upd_pc, upd_ghr);
    end
    check_count("reset");
    total++;
    if ({push_ready, commit_ready} !== 2'b10) begin
      bad++;
      $display("FAIL reset_ready got push_ready=%b commit_ready=%b want 1/0", push_ready, commit_ready);
    end
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) push_one(32'h200 + 32'(i * 4), 8'(i), i[0], i[1], i[2]);
    check_count("fill8");
    total++;
    if ({push_ready, commit_ready} !== 2'b01) begin
      bad++;
      $display("FAIL fill_ready got push_ready=%b commit_ready=%b want 0/1", push_ready, commit_ready);
    end
    push_one(32'hDEAD, 8'hEE, 1'b1, 1'b0, 1'b0);
    check_count("fill_overflow");
    for (int i = 0; i < 8; i++) commit_one(i[0]);
    check_count("fill_drain");
  endtask

  task automatic test_commit_compare;
    push_one(32'h100, 8'h5A, 1'b1, 1'b0, 1'b1);
    commit_one(1'b1);
    total++;
    if ({branch_we, misprediction, predictor_used, upd_mispred_2lvl, upd_mispred_gshare} !== 5'b11101
        || upd_pc !== 32'h100) begin
      bad++;
      $display("FAIL commit_compare got we=%b mis=%b used=%b m2=%b mg=%b pc=%h want 1 1 1 0 1 pc=00000100",
               branch_we, misprediction, predictor_used, upd_mispred_2lvl, upd_mispred_gshare, upd_pc);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 20; i++) begin
      push_one(32'h1000 + 32'(i * 16), 8'(8'h30 + i), i[0], i[1], i[2]);
      commit_one(i[0] ^ i[3]);
    end
    check_count("wrap");
  endtask

  task automatic test_back_to_back_simul;
    for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(i), 8'(i), i[1], i[0], i[0]);
    check_count("simul_pre");
    cycle(1'b1, 32'h3FF, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_count("simul_post");
    total++;
    if (upd_pc !== 32'h300) begin
      bad++;
      $display("FAIL simul_old_head got=%h want=00000300", upd_pc);
    end
    for (int i = 0; i < 3; i++) commit_one(~i[0]);
    check_count("simul_drain");
  endtask

  task automatic test_flush_pop;
    for (int i = 0; i < 5; i++) push_one(32'h500 + 32'(i), 8'(i), 1'b0, 1'b1, i[0]);
    check_count("flush_pre");
    cycle(1'b1, 32'hF00, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (branch_we !== 1'b1 || upd_pc !== 32'h500) begin
      bad++;
      $display("FAIL flush_pop_strobe got we=%b pc=%h want 1 pc=00000500", branch_we, upd_pc);
    end
    check_count("flush_post");
    total++;
    if (commit_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_commit_ready got=%b want=0", commit_ready);
    end
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_count("flush_push_dropped");
    push_one(32'h600, 8'h66, 1'b0, 1'b0, 1'b0);
    commit_one(1'b1);
  endtask

  task automatic test_empty_commit;
    commit_one(1'b1);
    check_count("empty_commit");
    total++;
    if ({push_ready, commit_ready} !== 2'b10) begin
      bad++;
      $display("FAIL empty_commit_ready got push_ready=%b commit_ready=%b want 1/0", push_ready, commit_ready);
    end
    push_one(32'h700, 8'h70, 1'b1, 1'b0, 1'b0);
    push_one(32'h704, 8'h71, 1'b0, 1'b1, 1'b1);
    commit_one(1'b0);
    commit_one(1'b0);
    check_count("empty_commit_after");
  endtask

  initial begin
    rst = 1'b1;
    push_valid = 1'b0; push_pc = '0; push_ghr = '0;
    push_pred_2lvl = 1'b0; push_pred_gshare = 1'b0; push_sel = 1'b0;
    commit_valid = 1'b0; commit_taken = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_fill;
    test_commit_compare;
    test_wrap;
    test_back_to_back_simul;
    test_flush_pop;
    test_empty_commit;
    repeat (3) @(posedge clk);
    #6;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
